nim_scaler_bank: RTL and testbench
==================================

NIM_SCALER_BANK -- requirements
Module: nim_scaler_bank

Interface
REQ-001 Parameter N_CH, default 8: number of NIM input channels, 1..32.
REQ-002 Parameter COUNT_W, default 32: counter width, 8..63.
REQ-003 Parameter DATA_W, default 64: register bus data width.
REQ-004 Parameter ADDR_W, default 32: register bus word-address width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Port clk, input, 1: sole clock; all logic rising-edge.
REQ-007 Port aresetn, input, 1: asynchronous active-low reset.
REQ-008 Port ch_in, input, N_CH: asynchronous NIM discriminator levels.
REQ-009 Port gate_in, input, 1: asynchronous count-enable gate, active high.
REQ-010 Port bus_addr, input, ADDR_W: word address.
REQ-011 Port bus_wdata, input, DATA_W: write data.
REQ-012 Port bus_wren, input, 1: single-cycle write strobe.
REQ-013 Port bus_rden, input, 1: single-cycle read strobe.
REQ-014 Port bus_rdata, output, DATA_W: read data, valid with bus_rdack.
REQ-015 Port bus_rdack, output, 1: read acknowledge pulse.
REQ-016 Port bus_wrack, output, 1: write acknowledge pulse.

Function
REQ-017 Each ch_in bit and gate_in SHALL pass a 2-flop synchronizer; a rising edge SHALL be detected on the synchronized level.
REQ-018 Live counter n SHALL increment by 1 on a detected edge when CTRL.run=1 and synchronized gate=1; an edge at ch_in is counted by the 4th rising clk.
REQ-019 Register map (word address): 0 CTRL, 1 STATUS, 2..2+N_CH-1 latched count of channel 0..N_CH-1; all other addresses read 0 and ignore writes.
REQ-020 CTRL bits: [0] run (read/write), [1] clear (self-clearing, reads 0), [2] latch (self-clearing, reads 0).
REQ-021 A write of latch=1 SHALL copy every live counter into its shadow register at the clk edge that registers the write; the shadow takes pre-increment values.
REQ-022 A write of clear=1 SHALL zero all live counters; clear beats a coincident edge; latch+clear in one write stores pre-clear values in shadows.
REQ-023 bus_rdack/bus_wrack SHALL pulse for exactly one cycle, the cycle after the strobe; bus_rdata holds its value until the next read.
REQ-024 Coincident bus_wren and bus_rden SHALL both be served and acknowledged in the same cycle; read returns pre-write contents.
REQ-025 Counts are zero-extended to DATA_W on readback.

Reset
REQ-026 On aresetn=0: live counters, shadows, CTRL, STATUS, synchronizers, bus_rdata=0, bus_rdack=0, bus_wrack=0, immediately.
REQ-027 A strobe pending when reset asserts SHALL be dropped without acknowledge.

Configuration
REQ-028 Macro NIM_SCALER_OVERFLOW_EN defined: live counters saturate at 2^COUNT_W-1 and set sticky STATUS bit n; clear resets the bit; latch does not.
REQ-029 Macro undefined: counters wrap to 0 silently and STATUS reads 0.

Verification
REQ-030 run=1, gate=1, 5 pulses on ch_in[3], latch, read addr 5 -> 5; other channels 0.
REQ-031 gate=0, 10 pulses on ch_in[0], latch, read addr 2 -> 0.
REQ-032 Count 7 on ch 1, write CTRL=0x7 (run, clear, latch) -> addr 3 reads 7; next latch reads 0.
REQ-033 COUNT_W=8, 257 pulses -> with NIM_SCALER_OVERFLOW_EN count 255 and STATUS=0x1; without, count 1 and STATUS=0.
REQ-034 Read addr 0x40 -> bus_rdata=0, bus_rdack one cycle after strobe; coincident wren/rden both acked same cycle.
REQ-035 aresetn pulse low mid-count -> all outputs 0 before next clk edge, counters 0 after release.

Source files
------------

// File: rtl/nim_scaler_bank.sv
// NIM scaler bank: synchronized edge counters with bus-controlled run/clear/latch and shadow readback.
// Optional NIM_SCALER_OVERFLOW_EN: saturating counters with sticky per-channel STATUS bits.
module nim_scaler_bank #(
  parameter int N_CH    = 8,
  parameter int COUNT_W = 32,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [N_CH-1:0]   ch_in,
  input  logic              gate_in,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_wren,
  input  logic              bus_rden,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rdack,
  output logic              bus_wrack
);

  logic [N_CH-1:0]    ch_s1, ch_s2, ch_d, edge_r;
  logic               gate_s1, gate_s2;
  logic               run;
  logic [COUNT_W-1:0] live   [N_CH];
  logic [COUNT_W-1:0] shadow [N_CH];
  logic [N_CH-1:0]    status;
  logic               wr_ctrl, do_clear, do_latch;
  logic [DATA_W-1:0]  rd_mux;

  assign wr_ctrl  = bus_wren && (bus_addr == '0);
  assign do_clear = wr_ctrl && bus_wdata[1];
  assign do_latch = wr_ctrl && bus_wdata[2];

  // Edge pulse is registered so an input edge lands on the 4th clk.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ch_s1   <= '0;
      ch_s2   <= '0;
      ch_d    <= '0;
      edge_r  <= '0;
      gate_s1 <= 1'b0;
      gate_s2 <= 1'b0;
    end else begin
      ch_s1   <= ch_in;
      ch_s2   <= ch_s1;
      ch_d    <= ch_s2;
      edge_r  <= ch_s2 & ~ch_d;
      gate_s1 <= gate_in;
      gate_s2 <= gate_s1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_CH; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (do_latch) shadow[i] <= live[i];
        if (do_clear) begin
          live[i] <= '0;
        end else if (edge_r[i] && run && gate_s2) begin
`ifdef NIM_SCALER_OVERFLOW_EN
          if (live[i] != '1) live[i] <= live[i] + 1'b1;
`else
          live[i] <= live[i] + 1'b1;
`endif
        end
      end
    end
  end

`ifdef NIM_SCALER_OVERFLOW_EN
  // Sticky bit set by the first increment attempted at full scale.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      status <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (do_clear) status[i] <= 1'b0;
        else if (edge_r[i] && run && gate_s2 && (live[i] == '1)) status[i] <= 1'b1;
      end
    end
  end
`else
  assign status = '0;
`endif

  always_comb begin
    rd_mux = '0;
    if (bus_addr == '0) rd_mux = DATA_W'(run);
    else if (bus_addr == ADDR_W'(1)) rd_mux = DATA_W'(status);
    for (int i = 0; i < N_CH; i++) begin
      if (bus_addr == ADDR_W'(i + 2)) rd_mux = DATA_W'(shadow[i]);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      run       <= 1'b0;
      bus_rdata <= '0;
      bus_rdack <= 1'b0;
      bus_wrack <= 1'b0;
    end else begin
      bus_rdack <= bus_rden;
      bus_wrack <= bus_wren;
      if (bus_rden) bus_rdata <= rd_mux;
      if (wr_ctrl) run <= bus_wdata[0];
    end
  end

endmodule

// File: tb/tb_nim_scaler_bank.sv
// Scoreboard bench for nim_scaler_bank; reference model counts pulses arithmetically.
module tb_nim_scaler_bank;
  localparam int N_CH    = 8;
  localparam int COUNT_W = 8;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 32;
  localparam longint unsigned CMAX = (64'd1 << COUNT_W) - 1;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic [N_CH-1:0]   ch_in = '0;
  logic              gate_in = 1'b0;
  logic [ADDR_W-1:0] bus_addr = '0;
  logic [DATA_W-1:0] bus_wdata = '0;
  logic              bus_wren = 1'b0;
  logic              bus_rden = 1'b0;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rdack;
  logic              bus_wrack;

  nim_scaler_bank #(.N_CH(N_CH), .COUNT_W(COUNT_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .aresetn(aresetn), .ch_in(ch_in), .gate_in(gate_in),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wren(bus_wren), .bus_rden(bus_rden),
    .bus_rdata(bus_rdata), .bus_rdack(bus_rdack), .bus_wrack(bus_wrack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  longint unsigned m_live [N_CH];
  longint unsigned m_shadow [N_CH];
  logic [N_CH-1:0] m_status;
  bit m_run, m_gate;

  logic [DATA_W-1:0] exp_q[$];
  int wr_pending = 0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_live[i] = 0;
      m_shadow[i] = 0;
    end
    m_status = '0;
    m_run = 0;
  endfunction

  function automatic logic [63:0] model_read(logic [ADDR_W-1:0] a);
    if (a == 0) return 64'(m_run);
    if (a == 1) begin
`ifdef NIM_SCALER_OVERFLOW_EN
      return 64'(m_status);
`else
      return 64'd0;
`endif
    end
    if (a >= 2 && a < 2 + N_CH) return m_shadow[a - 2];
    return 64'd0;
  endfunction

  function automatic void model_write(logic [ADDR_W-1:0] a, logic [63:0] d);
    if (a != 0) return;
    if (d[2]) for (int i = 0; i < N_CH; i++) m_shadow[i] = m_live[i];
    if (d[1]) begin
      for (int i = 0; i < N_CH; i++) m_live[i] = 0;
      m_status = '0;
    end
    m_run = d[0];
  endfunction

  function automatic void model_count(int c);
    if (!(m_run && m_gate)) return;
`ifdef NIM_SCALER_OVERFLOW_EN
    if (m_live[c] == CMAX) m_status[c] = 1'b1;
    else m_live[c] = m_live[c] + 1;
`else
    m_live[c] = (m_live[c] + 1) & CMAX;
`endif
  endfunction

  always @(negedge clk) begin
    if (bus_rdack) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rdack: got rdack=1, want no ack");
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("rdata", bus_rdata, e);
      end
    end
    if (bus_wrack) begin
      n_tests++;
      if (wr_pending == 0) begin
        n_fail++;
        $display("FAIL unexpected_wrack: got wrack=1, want no ack");
      end else begin
        wr_pending--;
      end
    end
  end

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_wren = 1'b1;
    wr_pending++;
    model_write(a, d);
    @(negedge clk);
    bus_wren = 1'b0;
    #1 check("wrack_latency", 64'(wr_pending), 64'd0);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    @(negedge clk);
    bus_addr = a; bus_rden = 1'b1;
    exp_q.push_back(model_read(a));
    @(negedge clk);
    bus_rden = 1'b0;
    #1 check("rdack_latency", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_both(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_wren = 1'b1; bus_rden = 1'b1;
    exp_q.push_back(model_read(a));
    wr_pending++;
    model_write(a, d);
    @(negedge clk);
    bus_wren = 1'b0; bus_rden = 1'b0;
    #1 check("both_ack", 64'(exp_q.size() + wr_pending), 64'd0);
  endtask

  task automatic pulse(input logic [N_CH-1:0] mask);
    @(negedge clk);
    ch_in = mask;
    repeat (3) @(negedge clk);
    ch_in = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N_CH; i++) if (mask[i]) model_count(i);
  endtask

  task automatic set_gate(input bit g);
    @(negedge clk);
    gate_in = g;
    m_gate = g;
    repeat (4) @(negedge clk);
  endtask

  task automatic read_all_ch();
    do_write(0, 64'(m_run) | 64'h4);
    for (int a = 2; a < 2 + N_CH; a++) do_read(ADDR_W'(a));
  endtask

  initial begin
    model_reset();
    m_gate = 0;
    repeat (3) @(negedge clk);
    check("rst_rdata", bus_rdata, 64'd0);
    check("rst_rdack", 64'(bus_rdack), 64'd0);
    check("rst_wrack", 64'(bus_wrack), 64'd0);
    aresetn = 1'b1;
    for (int a = 0; a < 2 + N_CH; a++) do_read(ADDR_W'(a));

    // five pulses on channel 3
    set_gate(1);
    do_write(0, 64'h1);
    repeat (5) pulse(8'h08);
    read_all_ch();

    // gate closed: nothing counted
    do_write(0, 64'h3);
    set_gate(0);
    repeat (10) pulse(8'h01);
    do_write(0, 64'h5);
    do_read(2);

    // latch+clear stores pre-clear value
    set_gate(1);
    do_write(0, 64'h3);
    repeat (7) pulse(8'h02);
    do_write(0, 64'h7);
    do_read(3);
    do_write(0, 64'h5);
    do_read(3);

    // 257 pulses: saturate or wrap
    do_write(0, 64'h3);
    repeat (257) pulse(8'h01);
    do_write(0, 64'h5);
    do_read(2);
    do_read(1);

    // unmapped addresses and coincident access
    do_read(32'h40);
    do_write(32'h40, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read(32'h40);
    do_both(2, 64'h0);
    do_both(0, 64'h4);
    do_both(0, 64'h5);
    do_read(0);

    for (int k = 0; k < 150; k++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: pulse(N_CH'($urandom));
        4: do_write(0, 64'($urandom_range(0, 7)));
        5: begin
          int sel;
          sel = $urandom_range(0, 12);
          do_read(sel == 12 ? ADDR_W'(32'h40) : ADDR_W'(sel));
        end
        6: set_gate(bit'($urandom_range(0, 1)));
        7: do_both(ADDR_W'($urandom_range(0, 11)), 64'($urandom_range(0, 7)));
        default: begin
          do_write(0, 64'(m_run) | 64'h4);
          do_read(ADDR_W'($urandom_range(2, 1 + N_CH)));
          do_read(1);
        end
      endcase
    end

    // asynchronous reset mid-count, with a read strobe pending
    set_gate(1);
    do_write(0, 64'h3);
    repeat (3) pulse(8'hFF);
    do_write(0, 64'h5);
    do_read(2);
    @(negedge clk);
    ch_in = 8'h10;
    bus_addr = 2;
    bus_rden = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    check("arst_rdata", bus_rdata, 64'd0);
    check("arst_rdack", 64'(bus_rdack), 64'd0);
    check("arst_wrack", 64'(bus_wrack), 64'd0);
    model_reset();
    exp_q.delete();
    wr_pending = 0;
    @(negedge clk);
    bus_rden = 1'b0;
    ch_in = '0;
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    read_all_ch();
    do_read(0);

    repeat (3) @(negedge clk);
    check("rd_queue_drained", 64'(exp_q.size()), 64'd0);
    check("wr_acks_drained", 64'(wr_pending), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
